// File: rtl/spi_int_pkg.sv
// Shared types and constants for the SPI FIFO-event interrupt generator.
//   int_state_t : per-channel interrupt FSM state
//   INT_DIR_*   : threshold direction encoding for dir_i
package spi_int_pkg;

    typedef enum logic [1:0] {
        INT_ARMED = 2'd0,
        INT_FIRE  = 2'd1,
        INT_WAIT  = 2'd2
    } int_state_t;

    localparam logic INT_DIR_LE = 1'b0;
    localparam logic INT_DIR_GE = 1'b1;

endpackage

// File: rtl/spi_int_chan.sv
// One interrupt channel: threshold comparator, re-arm transfer counter and
// ARMED -> FIRE -> WAIT state machine.
//   HCLK, HRESETn : clock, async active-low reset
//   clr_i         : synchronous soft clear (highest priority)
//   int_en_i      : allows ARMED -> FIRE
//   cnt_en_i      : 1 = re-arm on transfer count wrap, 0 = re-arm on rd_sta_i
//   dir_i         : 0 = level <= th, 1 = level >= th
//   level_i, th_i, cnt_i : FIFO level, threshold, re-arm count
//   xfer_i        : FIFO handshake this cycle
//   rd_sta_i      : status register read pulse
//   int_pulse_o   : registered one-cycle pulse, high while in FIRE
module spi_int_chan
    import spi_int_pkg::*;
#(
    parameter int unsigned LVL_W = 5
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             clr_i,
    input  logic             int_en_i,
    input  logic             cnt_en_i,
    input  logic             dir_i,
    input  logic [LVL_W-1:0] level_i,
    input  logic [LVL_W-1:0] th_i,
    input  logic [LVL_W-1:0] cnt_i,
    input  logic             xfer_i,
    input  logic             rd_sta_i,
    output logic             int_pulse_o
);

    int_state_t       state_q, state_d;
    logic [LVL_W-1:0] cnt_q, cnt_d;
    logic             pulse_d;

    logic [LVL_W-1:0] cnt_eff;
    logic [LVL_W-1:0] cnt_last;
    logic             cnt_wrap;
    logic             cond;

    // A count of zero behaves like one: every transfer wraps.
    assign cnt_eff  = (cnt_i == '0) ? LVL_W'(1) : cnt_i;
    assign cnt_last = cnt_eff - LVL_W'(1);
    assign cnt_wrap = xfer_i && (cnt_q == cnt_last);

    assign cond = (dir_i == INT_DIR_GE) ? (level_i >= th_i) : (level_i <= th_i);

    // Next state, counter and pulse; the counter runs in every state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;

        if (!cnt_en_i) begin
            cnt_d = '0;
        end else if (xfer_i) begin
            cnt_d = (cnt_q == cnt_last) ? '0 : cnt_q + LVL_W'(1);
        end

        case (state_q)
            INT_ARMED: if (int_en_i && cond) state_d = INT_FIRE;
            INT_FIRE:  state_d = INT_WAIT;
            INT_WAIT:  if (cnt_en_i ? cnt_wrap : rd_sta_i) state_d = INT_ARMED;
            default:   state_d = INT_ARMED;
        endcase

        if (clr_i) begin
            state_d = INT_ARMED;
            cnt_d   = '0;
        end

        // Registered copy of "in FIRE" so the output comes straight from a flop.
        pulse_d = (state_d == INT_FIRE);
    end

    // State, counter and pulse registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= INT_ARMED;
            cnt_q       <= '0;
            int_pulse_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            int_pulse_o <= pulse_d;
        end
    end

endmodule

// File: rtl/spi_fifo_int_gen.sv
// Parametrised FIFO-event interrupt generator for the APB SPI master.
// NUM_CH independent channels plus optional sticky, maskable pending bits.
// Build option: define SPI_INT_PEND_EN for the pending register and level irq;
// without it pend_o is 0 and irq_o is the OR of the channel pulses.
//   HCLK, HRESETn : clock, async active-low reset
//   clr_i         : synchronous soft clear
//   int_en_i, cnt_en_i, dir_i : per-channel controls
//   level_i, th_i, cnt_i      : packed per-channel fields, ch i at [i*LVL_W +: LVL_W]
//   xfer_i        : per-channel FIFO handshake
//   rd_sta_i      : status register read pulse
//   pend_clr_i    : W1C pulse per pending bit
//   irq_mask_i    : pending bits that drive irq_o
//   int_pulse_o   : per-channel one-cycle pulse
//   pend_o        : sticky pending bits
//   irq_o         : interrupt line
module spi_fifo_int_gen
    import spi_int_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned LVL_W  = 5
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    clr_i,
    input  logic [NUM_CH-1:0]       int_en_i,
    input  logic [NUM_CH-1:0]       cnt_en_i,
    input  logic [NUM_CH-1:0]       dir_i,
    input  logic [NUM_CH*LVL_W-1:0] level_i,
    input  logic [NUM_CH*LVL_W-1:0] th_i,
    input  logic [NUM_CH*LVL_W-1:0] cnt_i,
    input  logic [NUM_CH-1:0]       xfer_i,
    input  logic                    rd_sta_i,
    input  logic [NUM_CH-1:0]       pend_clr_i,
    input  logic [NUM_CH-1:0]       irq_mask_i,
    output logic [NUM_CH-1:0]       int_pulse_o,
    output logic [NUM_CH-1:0]       pend_o,
    output logic                    irq_o
);

    // One channel instance per monitored FIFO.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        spi_int_chan #(
            .LVL_W (LVL_W)
        ) u_chan (
            .HCLK        (HCLK),
            .HRESETn     (HRESETn),
            .clr_i       (clr_i),
            .int_en_i    (int_en_i[g]),
            .cnt_en_i    (cnt_en_i[g]),
            .dir_i       (dir_i[g]),
            .level_i     (level_i[g*LVL_W +: LVL_W]),
            .th_i        (th_i[g*LVL_W +: LVL_W]),
            .cnt_i       (cnt_i[g*LVL_W +: LVL_W]),
            .xfer_i      (xfer_i[g]),
            .rd_sta_i    (rd_sta_i),
            .int_pulse_o (int_pulse_o[g])
        );
    end

`ifdef SPI_INT_PEND_EN
    logic [NUM_CH-1:0] pend_q;

    // Sticky pending bits: set at the end of a FIRE cycle, set beats W1C.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_q <= '0;
        end else if (clr_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~pend_clr_i) | int_pulse_o;
        end
    end

    assign pend_o = pend_q;
    assign irq_o  = |(pend_q & irq_mask_i);
`else
    logic unused_pend_inputs;

    // Legacy event behaviour: irq follows the channel pulses.
    assign unused_pend_inputs = ^{pend_clr_i, irq_mask_i};
    assign pend_o             = '0;
    assign irq_o              = |int_pulse_o;
`endif

endmodule

// File: tb/tb_spi_fifo_int_gen.sv
module tb_spi_fifo_int_gen;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned LVL_W  = 5;
`ifdef SPI_INT_PEND_EN
    localparam bit PEND_ON = 1'b1;
`else
    localparam bit PEND_ON = 1'b0;
`endif

    logic              HCLK;
    logic              HRESETn;
    logic              clr_i;
    logic [NUM_CH-1:0] int_en_i, cnt_en_i, dir_i, xfer_i, pend_clr_i, irq_mask_i;
    logic              rd_sta_i;
    logic [LVL_W-1:0]  lvl0, lvl1, th0, th1, cnt0, cnt1;
    logic [NUM_CH*LVL_W-1:0] level_i, th_i, cnt_i;
    logic [NUM_CH-1:0] int_pulse_o, pend_o;
    logic              irq_o;

    int n_cmp = 0;
    int n_err = 0;

    assign level_i = {lvl1, lvl0};
    assign th_i    = {th1, th0};
    assign cnt_i   = {cnt1, cnt0};

    spi_fifo_int_gen #(
        .NUM_CH (NUM_CH),
        .LVL_W  (LVL_W)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .clr_i       (clr_i),
        .int_en_i    (int_en_i),
        .cnt_en_i    (cnt_en_i),
        .dir_i       (dir_i),
        .level_i     (level_i),
        .th_i        (th_i),
        .cnt_i       (cnt_i),
        .xfer_i      (xfer_i),
        .rd_sta_i    (rd_sta_i),
        .pend_clr_i  (pend_clr_i),
        .irq_mask_i  (irq_mask_i),
        .int_pulse_o (int_pulse_o),
        .pend_o      (pend_o),
        .irq_o       (irq_o)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Expected pend/irq are given for the pending build; the legacy build
    // expects pend 0 and irq equal to the OR of the pulses.
    task automatic chk(input string tag, input logic [1:0] e_pulse,
                       input logic [1:0] e_pend, input logic e_irq);
        logic [1:0] ep;
        logic       ei;
        ep = PEND_ON ? e_pend : 2'b00;
        ei = PEND_ON ? e_irq  : |e_pulse;
        n_cmp++;
        assert (int_pulse_o === e_pulse) else begin
            n_err++;
            $error("FAIL %s.pulse observed=%b expected=%b", tag, int_pulse_o, e_pulse);
        end
        n_cmp++;
        assert (pend_o === ep) else begin
            n_err++;
            $error("FAIL %s.pend observed=%b expected=%b", tag, pend_o, ep);
        end
        n_cmp++;
        assert (irq_o === ei) else begin
            n_err++;
            $error("FAIL %s.irq observed=%b expected=%b", tag, irq_o, ei);
        end
    endtask

    initial begin
        HRESETn = 1'b0; clr_i = 1'b0; rd_sta_i = 1'b0;
        int_en_i = '0; cnt_en_i = '0; dir_i = '0; xfer_i = '0;
        pend_clr_i = '0; irq_mask_i = 2'b01;
        lvl0 = '0; lvl1 = '0; th0 = '0; th1 = '0; cnt0 = '0; cnt1 = '0;

        // Reset
        tick(); tick();
        chk("reset", 2'b00, 2'b00, 1'b0);
        HRESETn = 1'b1;
        tick();
        chk("idle", 2'b00, 2'b00, 1'b0);

        // Direction LE on ch0, re-arm on status read
        dir_i[0] = 1'b0; th0 = 5'd2; lvl0 = 5'd5; int_en_i = 2'b01;
        tick();                        chk("le_nocond", 2'b00, 2'b00, 1'b0);
        lvl0 = 5'd2;
        tick();                        chk("le_fire",   2'b01, 2'b00, 1'b0);
        tick();                        chk("le_pend",   2'b00, 2'b01, 1'b1);
        tick();                        chk("le_wait1",  2'b00, 2'b01, 1'b1);
        tick();                        chk("le_wait2",  2'b00, 2'b01, 1'b1);
        rd_sta_i = 1'b1; tick(); rd_sta_i = 1'b0;
                                       chk("le_rearm",  2'b00, 2'b01, 1'b1);
        tick();                        chk("le_refire", 2'b01, 2'b01, 1'b1);
        tick();                        chk("le_wait3",  2'b00, 2'b01, 1'b1);
        int_en_i[0] = 1'b0;
        rd_sta_i = 1'b1; tick(); rd_sta_i = 1'b0;
                                       chk("le_dis_arm", 2'b00, 2'b01, 1'b1);
        tick();                        chk("le_dis",    2'b00, 2'b01, 1'b1);
        pend_clr_i = 2'b01; tick(); pend_clr_i = 2'b00;
                                       chk("le_w1c",    2'b00, 2'b00, 1'b0);

        // Direction GE on ch1 with count re-arm
        dir_i[1] = 1'b1; cnt_en_i[1] = 1'b1; cnt1 = 5'd4; th1 = 5'd3; lvl1 = 5'd3;
        int_en_i[1] = 1'b1;
        tick();                        chk("ge_fire",   2'b10, 2'b00, 1'b0);
        irq_mask_i = 2'b11;
        tick();                        chk("ge_wait",   2'b00, 2'b10, 1'b1);
        rd_sta_i = 1'b1; tick(); rd_sta_i = 1'b0;
                                       chk("ge_rdsta",  2'b00, 2'b10, 1'b1);
        tick();                        chk("ge_rdsta2", 2'b00, 2'b10, 1'b1);
        xfer_i = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();                    chk("ge_xfer",   2'b00, 2'b10, 1'b1);
        end
        tick(); xfer_i = 2'b00;        chk("ge_xfer4",  2'b00, 2'b10, 1'b1);
        tick();                        chk("ge_refire", 2'b10, 2'b10, 1'b1);
        tick();                        chk("ge_wait2",  2'b00, 2'b10, 1'b1);

        // Count of 0 and of 1: every transfer re-arms
        cnt1 = 5'd0;
        xfer_i = 2'b10; tick(); xfer_i = 2'b00;
                                       chk("c0_arm",    2'b00, 2'b10, 1'b1);
        tick();                        chk("c0_fire",   2'b10, 2'b10, 1'b1);
        tick();                        chk("c0_wait",   2'b00, 2'b10, 1'b1);
        cnt1 = 5'd1;
        xfer_i = 2'b10; tick(); xfer_i = 2'b00;
                                       chk("c1_arm",    2'b00, 2'b10, 1'b1);
        tick();                        chk("c1_fire",   2'b10, 2'b10, 1'b1);
        tick();                        chk("c1_wait",   2'b00, 2'b10, 1'b1);

        // Pending: set beats clear, mask
        pend_clr_i = 2'b11; tick(); pend_clr_i = 2'b00;
                                       chk("pd_clrall", 2'b00, 2'b00, 1'b0);
        irq_mask_i = 2'b10; int_en_i[0] = 1'b1;
        tick();                        chk("pd_fire",   2'b01, 2'b00, 1'b0);
        pend_clr_i = 2'b01; tick(); pend_clr_i = 2'b00;
                                       chk("pd_setwins", 2'b00, 2'b01, 1'b0);
        tick();                        chk("pd_masked", 2'b00, 2'b01, 1'b0);
        pend_clr_i = 2'b01; tick(); pend_clr_i = 2'b00;
                                       chk("pd_w1c",    2'b00, 2'b00, 1'b0);

        // Soft clear with ch1 in WAIT and r_cnt=2
        cnt1 = 5'd4;
        xfer_i = 2'b10; tick();        chk("cl_x1",     2'b00, 2'b00, 1'b0);
        tick(); xfer_i = 2'b00;        chk("cl_x2",     2'b00, 2'b00, 1'b0);
        irq_mask_i = 2'b11;
        rd_sta_i = 1'b1; tick(); rd_sta_i = 1'b0;
                                       chk("cl_ch0arm", 2'b00, 2'b00, 1'b0);
        tick();                        chk("cl_ch0fire", 2'b01, 2'b00, 1'b0);
        tick();                        chk("cl_ch0pend", 2'b00, 2'b01, 1'b1);
        clr_i = 1'b1; tick(); clr_i = 1'b0;
                                       chk("cl_clr",    2'b00, 2'b00, 1'b0);
        tick();                        chk("cl_bothfire", 2'b11, 2'b00, 1'b0);
        int_en_i[0] = 1'b0;
        tick();                        chk("cl_wait",   2'b00, 2'b11, 1'b1);
        xfer_i = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();                    chk("cl_cnt",    2'b00, 2'b11, 1'b1);
        end
        tick(); xfer_i = 2'b00;        chk("cl_cnt4",   2'b00, 2'b11, 1'b1);
        tick();                        chk("cl_refire", 2'b10, 2'b11, 1'b1);

        // Asynchronous reset in the middle of FIRE
        #2 HRESETn = 1'b0;
        #1                             chk("rst_async", 2'b00, 2'b00, 1'b0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;                chk("rst_held",  2'b00, 2'b00, 1'b0);
        tick();                        chk("rst_fire",  2'b10, 2'b00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_fifo_int_gen.md
# spi_fifo_int_gen

Parametrised FIFO-event interrupt generator for the APB SPI master family, replacing the fixed TX/RX interrupt logic in the SPI master top level. It supports NUM_CH independent channels, each with its own threshold direction, enable, and re-arm policy (transfer count or status-read acknowledge). It also adds an optional sticky, maskable pending register and a level interrupt line. It sits between the FIFO element counters / handshakes and the APB register file and event outputs.

## Interface
- NUM_CH, 2, number of monitored FIFO channels (1..8)
- LVL_W, 5, width of level, threshold and count fields; holds BUFFER_DEPTH inclusive
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous, active-low reset
- clr_i  in  1  synchronous soft clear (spi_swrst)
- int_en_i  in  NUM_CH  per-channel interrupt enable
- cnt_en_i  in  NUM_CH  1: re-arm after cnt transfers; 0: re-arm on status read
- dir_i  in  NUM_CH  0: fire when level <= th (TX style); 1: fire when level >= th (RX style)
- level_i  in  NUM_CH*LVL_W  FIFO element counts, channel i at [i*LVL_W +: LVL_W]
- th_i  in  NUM_CH*LVL_W  thresholds, same packing
- cnt_i  in  NUM_CH*LVL_W  re-arm transfer counts, same packing
- xfer_i  in  NUM_CH  FIFO-side handshake fired (valid & ready) this cycle
- rd_sta_i  in  1  one-cycle pulse on APB read of the interrupt status register
- pend_clr_i  in  NUM_CH  W1C pulse per pending bit
- irq_mask_i  in  NUM_CH  1 = pending bit contributes to irq_o
- int_pulse_o  out  NUM_CH  one-cycle interrupt pulse per channel
- pend_o  out  NUM_CH  sticky pending bits
- irq_o  out  1  interrupt line

## Operation
- Each channel runs a 3-state FSM:
  - ARMED: if int_en_i[i] && cond[i], go to FIRE.
  - FIRE: int_pulse_o[i]=1, go to WAIT.
  - WAIT:
    - If cnt_en_i[i]: go to ARMED when xfer_i[i] && r_cnt[i]==cnt_eff-1.
    - Otherwise: go to ARMED on rd_sta_i.
- cond[i] = dir_i[i] ? (level >= th) : (level <= th). Comparisons are unsigned, LVL_W bits.
- Transfer counter r_cnt[i], LVL_W bits:
  - When cnt_en_i[i]=0, it is held at 0.
  - Otherwise it increments on xfer_i[i] and wraps to 0 after reaching cnt_eff-1.
  - cnt_eff = (cnt_i==0) ? 1 : cnt_i. With cnt_i of 0 or 1, every transfer re-arms the channel.
- The counter counts in every state. Only the wrap event in WAIT re-arms the channel.
- Disabling int_en_i does not abort FIRE/WAIT; it only blocks ARMED to FIRE.
- clr_i has the highest synchronous priority. It forces all FSMs to ARMED, r_cnt to 0, and pend_o to 0.
- pend_o[i] is set on the edge ending a FIFO cycle for channel i. It is cleared by pend_clr_i[i]. If set and clear occur in the same cycle, set wins.
- irq_o = |(pend_o & irq_mask_i), combinational from registers.

## Timing
- Reset values:
  - All FSMs in ARMED, all counters 0.
  - int_pulse_o=0, pend_o=0, irq_o=0.
- Latency:
  - cond and enable true in cycle n, so int_pulse_o is high in cycle n+1 (Moore output, registered state).
  - pend_o and irq_o go high in cycle n+2.
- Minimum re-fire spacing is 3 cycles (FIRE, WAIT, ARMED). If cond stays true after re-arm, the channel fires again one cycle later.
- The rd_sta_i pulse is consumed only by channels in WAIT with cnt_en=0. A pulse seen in ARMED or FIRE is ignored.
- xfer_i landing on the wrap in the same cycle as the FIFO-to-WAIT transition is counted but does not re-arm.
- HRESETn assertion mid-operation clears everything immediately (asynchronous). Deassertion is synchronous to HCLK.

## Configuration
- SPI_INT_PEND_EN defined: the sticky pend_o register and W1C/mask logic are built, and irq_o is a level signal as described.
- SPI_INT_PEND_EN undefined:
  - pend_o is tied to 0 and pend_clr_i/irq_mask_i are ignored.
  - irq_o = |int_pulse_o, a one-cycle pulse matching the legacy events_o[0] behaviour.

## Structure
- Package spi_int_pkg:
  - typedef enum logic [1:0] {INT_ARMED, INT_FIRE, INT_WAIT} int_state_t.
  - Constant INT_DIR_LE=0 / INT_DIR_GE=1.
- Sub-module spi_int_chan: one FSM, counter and comparator.
- The top level generates NUM_CH instances plus the shared pending/irq logic.

## Test plan
- Direction LE: dir=0, th=2, level 5 to 2 in cycle 10 -> int_pulse_o high in cycle 11 only; pend_o and irq_o high from cycle 12. No re-fire until rd_sta_i is pulsed, then a re-fire 1 cycle later while level stays at 2.
- Direction GE with count re-arm: dir=1, cnt_en=1, cnt=4, th=3, level held at 3 -> one pulse. Four xfer_i pulses -> re-arm on the 4th, re-fire 2 cycles after the 4th xfer. rd_sta_i alone has no effect.
- Count corner case: cnt_i=0 with cnt_en=1 -> each xfer_i re-arms the channel, identical to cnt_i=1.
- Pending: simultaneous FIRE on ch0 and pend_clr_i[0] -> pend_o[0] stays 1. With irq_mask_i=2'b10 and only ch0 pending, irq_o=0. A later pend_clr_i[0] clears ch0.
- Clear/reset: clr_i asserted while ch1 is in WAIT with r_cnt=2 -> next cycle ARMED, r_cnt=0, pend_o=0. HRESETn pulse mid-FIRE -> int_pulse_o drops asynchronously.
- Macro off: with SPI_INT_PEND_EN undefined, irq_o mirrors the OR of int_pulse_o for exactly 1 cycle, and pend_o stays 0.
